// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: state encoding and default sizes for the register file dump reader.
package reg_dump_pkg;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
endpackage

// File: rtl/reg_file_dump_reader.sv
// reg_file_dump_reader: walks R0..NUM_REGS-1 through one file read port and streams the words out.
// Optional trailing checksum word when REG_DUMP_CHECKSUM_EN is defined.
module reg_file_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  output logic [ADDR_W-1:0] Rd_Addr,
  input  logic [DATA_W-1:0] Rd_Data,
  output logic              Dout_Valid,
  input  logic              Dout_Ready,
  output logic [DATA_W-1:0] Dout_Data,
  output logic [ADDR_W-1:0] Dout_Idx,
  output logic              Dout_Last,
`ifdef REG_DUMP_CHECKSUM_EN
  output logic              Dout_Csum,
`endif
  output logic              Busy,
  output logic              Done
);
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic hs, at_last;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif
  assign Rd_Addr = ptr;
  assign hs = Dout_Valid && Dout_Ready;
  assign at_last = ptr == ADDR_W'(NUM_REGS - 1);
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      ptr <= '0;
      Dout_Valid <= 1'b0;
      Dout_Data <= '0;
      Dout_Idx <= '0;
      Dout_Last <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      acc <= '0;
      Dout_Csum <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      if (Abort) begin
        state <= IDLE;
        ptr <= '0;
        Dout_Valid <= 1'b0;
        Dout_Last <= 1'b0;
        Busy <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
        acc <= '0;
        Dout_Csum <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (Start) begin
            state <= READ;
            ptr <= '0;
            Busy <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
            acc <= '0;
`endif
          end
          READ: begin
            Dout_Data <= Rd_Data;
            Dout_Idx <= ptr;
`ifdef REG_DUMP_CHECKSUM_EN
            Dout_Last <= 1'b0;
`else
            Dout_Last <= at_last;
`endif
            Dout_Valid <= 1'b1;
            state <= SEND;
          end
          SEND: if (hs) begin
            Dout_Valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acc <= acc + Dout_Data;
`endif
            if (!at_last) begin
              ptr <= ptr + ADDR_W'(1);
              state <= READ;
            end else begin
`ifdef REG_DUMP_CHECKSUM_EN
              // trailing word carries the sum including the word just accepted
              state <= CSUM;
              Dout_Valid <= 1'b1;
              Dout_Data <= acc + Dout_Data;
              Dout_Idx <= '0;
              Dout_Last <= 1'b1;
              Dout_Csum <= 1'b1;
`else
              state <= DONE;
              Dout_Last <= 1'b0;
`endif
            end
          end
`ifdef REG_DUMP_CHECKSUM_EN
          CSUM: if (hs) begin
            Dout_Valid <= 1'b0;
            Dout_Last <= 1'b0;
            Dout_Csum <= 1'b0;
            state <= DONE;
          end
`endif
          DONE: begin
            Done <= 1'b1;
            ptr <= '0;
            Busy <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            Busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
